// File: rtl/hol_game_core.sv
// Higher-or-lower guessing game: a free-running Galois LFSR supplies numbers,
// the FSM tracks per-game score and lives plus a best-score-since-reset.
module hol_game_core #(
    parameter int          NUM_W   = 8,
    parameter int          MAX_NUM = 99,
    parameter int          LIVES   = 3,
    parameter int          SCORE_W = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               higher_btn,
    input  logic               lower_btn,
    input  logic               confirm_btn,
    output logic [2:0]         state,
    output logic [NUM_W-1:0]   cur_num,
    output logic [NUM_W-1:0]   next_num,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [3:0]         lives_left,
    output logic [2:0]         rgb_led
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DRAW_FIRST = 3'd1,
        S_GUESS      = 3'd2,
        S_DRAW_NEXT  = 3'd3,
        S_RESULT     = 3'd4,
        S_GAME_OVER  = 3'd5
    } state_e;

    localparam logic [NUM_W-1:0]   MAX_V     = NUM_W'(MAX_NUM);
    localparam logic [3:0]         LIVES_V   = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    // Right-shift Galois toggle mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0]        LFSR_TAPS = 16'hB400;

    localparam logic [2:0] RGB_OFF   = 3'b000;
    localparam logic [2:0] RGB_GUESS = 3'b001;
    localparam logic [2:0] RGB_WIN   = 3'b010;
    localparam logic [2:0] RGB_LOSE  = 3'b100;
    localparam logic [2:0] RGB_OVER  = 3'b101;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [NUM_W-1:0]   cur_q, cur_d;
    logic [NUM_W-1:0]   next_q, next_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [3:0]         lives_q, lives_d;
    logic               dir_hi_q, dir_hi_d;
    logic [2:0]         rgb_q, rgb_d;

    logic [NUM_W-1:0]   cand;
    logic               cand_in_range;
    logic               guess_correct;

    assign cand          = lfsr_q[NUM_W-1:0];
    assign cand_in_range = (cand <= MAX_V);
    assign guess_correct = dir_hi_q ? (cand > cur_q) : (cand < cur_q);

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        state_d  = state_q;
        cur_d    = cur_q;
        next_d   = next_q;
        score_d  = score_q;
        high_d   = high_q;
        lives_d  = lives_q;
        dir_hi_d = dir_hi_q;
        rgb_d    = rgb_q;

        // Buttons are only looked at in the states that consume them, so a
        // pulse landing anywhere else simply vanishes.
        case (state_q)
            S_IDLE: begin
                if (confirm_btn) begin
                    state_d = S_DRAW_FIRST;
                    score_d = '0;
                    lives_d = LIVES_V;
                    next_d  = '0;
                    rgb_d   = RGB_OFF;
                end
            end
            S_DRAW_FIRST: begin
                if (cand_in_range) begin
                    cur_d   = cand;
                    state_d = S_GUESS;
                    rgb_d   = RGB_GUESS;
                end
            end
            S_GUESS: begin
                if (higher_btn ^ lower_btn) begin
                    dir_hi_d = higher_btn;
                    state_d  = S_DRAW_NEXT;
                    rgb_d    = RGB_OFF;
                end
            end
            S_DRAW_NEXT: begin
                if (cand_in_range && (cand != cur_q)) begin
                    next_d  = cand;
                    state_d = S_RESULT;
                    if (guess_correct) begin
                        rgb_d = RGB_WIN;
                        if (score_q != SCORE_SAT) begin
                            score_d = score_q + SCORE_ONE;
                        end
                    end else begin
                        rgb_d = RGB_LOSE;
                        if (lives_q != 4'd0) begin
                            lives_d = lives_q - 4'd1;
                        end
                    end
                end
            end
            S_RESULT: begin
                if (confirm_btn) begin
                    if (lives_q == 4'd0) begin
                        state_d = S_GAME_OVER;
                        rgb_d   = RGB_OVER;
                        high_d  = (score_q > high_q) ? score_q : high_q;
                    end else begin
                        cur_d   = next_q;
                        state_d = S_GUESS;
                        rgb_d   = RGB_GUESS;
                    end
                end
            end
            S_GAME_OVER: begin
                if (confirm_btn) begin
                    state_d = S_DRAW_FIRST;
                    score_d = '0;
                    lives_d = LIVES_V;
                    next_d  = '0;
                    rgb_d   = RGB_OFF;
                end
            end
            default: begin
                state_d = S_IDLE;
                rgb_d   = RGB_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            cur_q    <= '0;
            next_q   <= '0;
            score_q  <= '0;
            high_q   <= '0;
            lives_q  <= LIVES_V;
            dir_hi_q <= 1'b0;
            rgb_q    <= RGB_OFF;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            score_q  <= score_d;
            high_q   <= high_d;
            lives_q  <= lives_d;
            dir_hi_q <= dir_hi_d;
            rgb_q    <= rgb_d;
        end
    end

    assign state      = state_q;
    assign cur_num    = cur_q;
    assign next_num   = next_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign lives_left = lives_q;
    assign rgb_led    = rgb_q;

endmodule

// File: tb/tb_hol_game_core.sv
// Bench for hol_game_core: a default instance and a MAX_NUM=1/LIVES=1/SCORE_W=2
// instance, checked cycle by cycle against expected snapshots.
`timescale 1ns/1ps
module tb_hol_game_core;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DF    = 3'd1;
    localparam logic [2:0] ST_GUESS = 3'd2;
    localparam logic [2:0] ST_DN    = 3'd3;
    localparam logic [2:0] ST_RES   = 3'd4;
    localparam logic [2:0] ST_GO    = 3'd5;
    localparam int         BOUND    = 20000;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic [7:0]  cur;
        logic [7:0]  nxt;
        logic [7:0]  sc;
        logic [7:0]  hi;
        logic [3:0]  lv;
        logic [2:0]  rgb;
    } snap_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cyc = 32'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // ---------------- DUTs ----------------
    logic       d_hi, d_lo, d_cf;
    logic [2:0] d_state, d_rgb;
    logic [7:0] d_cur, d_next, d_score, d_high;
    logic [3:0] d_lives;

    logic       m_hi, m_lo, m_cf;
    logic [2:0] m_state, m_rgb;
    logic [7:0] m_cur, m_next;
    logic [1:0] m_score, m_high;
    logic [3:0] m_lives;

    hol_game_core u_def (
        .clk(clk), .reset(rst),
        .higher_btn(d_hi), .lower_btn(d_lo), .confirm_btn(d_cf),
        .state(d_state), .cur_num(d_cur), .next_num(d_next),
        .score(d_score), .high_score(d_high), .lives_left(d_lives), .rgb_led(d_rgb)
    );

    hol_game_core #(.NUM_W(8), .MAX_NUM(1), .LIVES(1), .SCORE_W(2), .SEED(16'hACE1)) u_min (
        .clk(clk), .reset(rst),
        .higher_btn(m_hi), .lower_btn(m_lo), .confirm_btn(m_cf),
        .state(m_state), .cur_num(m_cur), .next_num(m_next),
        .score(m_score), .high_score(m_high), .lives_left(m_lives), .rgb_led(m_rgb)
    );

    // ---------------- reference LFSR ----------------
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) begin
            y[15] = ~y[15];  // x^16
            y[13] = ~y[13];  // x^14
            y[12] = ~y[12];  // x^13
            y[10] = ~y[10];  // x^11
        end
        return y;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_adv(m_lfsr);
    end

    // ---------------- expected game state per instance ----------------
    logic [2:0] e_st  [2];
    logic [7:0] e_cur [2];
    logic [7:0] e_nxt [2];
    logic [7:0] e_sc  [2];
    logic [7:0] e_hi  [2];
    logic [3:0] e_lv  [2];
    logic [2:0] e_rgb [2];
    logic       e_dir [2];

    snap_t exp_q0[$];
    snap_t exp_q1[$];

    int checks = 0;
    int errors = 0;
    int draws  = 0;

    function automatic int max_of(input int s);   return (s != 0) ? 1 : 99;  endfunction
    function automatic int lives_of(input int s); return (s != 0) ? 1 : 3;   endfunction
    function automatic int sat_of(input int s);   return (s != 0) ? 3 : 255; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input logic [31:0] c);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, c, act, exp);
        end
    endtask

    function automatic snap_t exp_snap(input int s, input logic [31:0] c);
        snap_t e;
        e.cyc = c;     e.st = e_st[s]; e.cur = e_cur[s]; e.nxt = e_nxt[s];
        e.sc  = e_sc[s]; e.hi = e_hi[s]; e.lv = e_lv[s]; e.rgb = e_rgb[s];
        return e;
    endfunction

    function automatic snap_t act_snap(input int s);
        snap_t a;
        a.cyc = cyc;
        if (s == 0) begin
            a.st = d_state; a.cur = d_cur; a.nxt = d_next; a.sc = d_score;
            a.hi = d_high;  a.lv = d_lives; a.rgb = d_rgb;
        end else begin
            a.st = m_state; a.cur = m_cur; a.nxt = m_next; a.sc = {6'b0, m_score};
            a.hi = {6'b0, m_high}; a.lv = m_lives; a.rgb = m_rgb;
        end
        return a;
    endfunction

    task automatic compare(input int s, input snap_t e, input snap_t a);
        string p;
        p = (s != 0) ? "min" : "def";
        chk({p, "_state"},      32'(a.st),  32'(e.st),  e.cyc);
        chk({p, "_cur_num"},    32'(a.cur), 32'(e.cur), e.cyc);
        chk({p, "_next_num"},   32'(a.nxt), 32'(e.nxt), e.cyc);
        chk({p, "_score"},      32'(a.sc),  32'(e.sc),  e.cyc);
        chk({p, "_high_score"}, 32'(a.hi),  32'(e.hi),  e.cyc);
        chk({p, "_lives_left"}, 32'(a.lv),  32'(e.lv),  e.cyc);
        chk({p, "_rgb_led"},    32'(a.rgb), 32'(e.rgb), e.cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int s);
        snap_t a, e;
        a = act_snap(s);
        if (s == 0) begin
            while (exp_q0.size() > 0 && exp_q0[0].cyc <= cyc) begin
                e = exp_q0.pop_front();
                compare(0, e, a);
            end
            if (a.st == ST_RES)
                chk("def_draw_legal", {31'b0, (a.cur <= 8'd99 && a.nxt <= 8'd99 && a.nxt != a.cur)}, 32'd1, a.cyc);
        end else begin
            while (exp_q1.size() > 0 && exp_q1[0].cyc <= cyc) begin
                e = exp_q1.pop_front();
                compare(1, e, a);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0);
        mon(1);
    end

    // ---------------- driver tasks ----------------
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e_st[i] = ST_IDLE; e_cur[i] = 8'd0; e_nxt[i] = 8'd0; e_sc[i] = 8'd0;
            e_hi[i] = 8'd0; e_lv[i] = 4'(lives_of(i)); e_rgb[i] = 3'b000; e_dir[i] = 1'b0;
        end
    endtask

    // Expected values describe the state after the coming rising edge.
    task automatic step();
        exp_q0.push_back(exp_snap(0, cyc + 32'd1));
        exp_q1.push_back(exp_snap(1, cyc + 32'd1));
        @(negedge clk);
        {d_hi, d_lo, d_cf, m_hi, m_lo, m_cf} = 6'b0;
    endtask

    task automatic drive_btn(input int s, input logic h, input logic l, input logic c);
        if (s == 0) begin d_hi = h; d_lo = l; d_cf = c; end
        else        begin m_hi = h; m_lo = l; m_cf = c; end
    endtask

    task automatic press_confirm(input int s);
        drive_btn(s, 1'b0, 1'b0, 1'b1);
        case (e_st[s])
            ST_IDLE, ST_GO: begin
                e_st[s] = ST_DF; e_sc[s] = 8'd0; e_lv[s] = 4'(lives_of(s));
                e_nxt[s] = 8'd0; e_rgb[s] = 3'b000;
            end
            ST_RES: begin
                if (e_lv[s] == 4'd0) begin
                    e_st[s] = ST_GO; e_rgb[s] = 3'b101;
                    if (e_sc[s] > e_hi[s]) e_hi[s] = e_sc[s];
                end else begin
                    e_cur[s] = e_nxt[s]; e_st[s] = ST_GUESS; e_rgb[s] = 3'b001;
                end
            end
            default: ;
        endcase
        step();
    endtask

    task automatic press_dir(input int s, input logic h, input logic l);
        drive_btn(s, h, l, 1'b0);
        if (e_st[s] == ST_GUESS && (h ^ l)) begin
            e_dir[s] = h; e_st[s] = ST_DN; e_rgb[s] = 3'b000;
        end
        step();
    endtask

    // For the MAX_NUM=1 instance: higher is right exactly when cur_num is 0.
    task automatic guess(input int s, input logic correct);
        logic h;
        h = (e_cur[s] == 8'd0) ? correct : ~correct;
        press_dir(s, h, ~h);
    endtask

    task automatic wait_draw(input int s, input logic noise);
        int n;
        logic [7:0] cand;
        n = 0;
        while ((e_st[s] == ST_DF || e_st[s] == ST_DN) && n < BOUND) begin
            cand = m_lfsr[7:0];
            if (noise) drive_btn(s, 1'b1, 1'b1, 1'b1);
            if (e_st[s] == ST_DF && int'(cand) <= max_of(s)) begin
                e_cur[s] = cand; e_st[s] = ST_GUESS; e_rgb[s] = 3'b001; draws++;
            end else if (e_st[s] == ST_DN && int'(cand) <= max_of(s) && cand != e_cur[s]) begin
                e_nxt[s] = cand; e_st[s] = ST_RES; draws++;
                if ((e_dir[s] && cand > e_cur[s]) || (!e_dir[s] && cand < e_cur[s])) begin
                    e_rgb[s] = 3'b010;
                    if (int'(e_sc[s]) != sat_of(s)) e_sc[s] = e_sc[s] + 8'd1;
                end else begin
                    e_rgb[s] = 3'b100;
                    e_lv[s]  = e_lv[s] - 4'd1;
                end
            end
            step();
            n++;
        end
        chk("draw_bound", {31'b0, (n < BOUND)}, 32'd1, cyc);
    endtask

    // Reset raised between edges must clear outputs without waiting for clk.
    task automatic async_reset_check();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare(0, exp_snap(0, cyc), act_snap(0));
        compare(1, exp_snap(1, cyc), act_snap(1));
        step();
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        {d_hi, d_lo, d_cf, m_hi, m_lo, m_cf} = 6'b0;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        compare(0, exp_snap(0, cyc), act_snap(0));
        compare(1, exp_snap(1, cyc), act_snap(1));
        repeat (10) step();
        rst = 1'b0;
        repeat (3) step();

        // Non-confirm pulses in IDLE do nothing.
        press_dir(0, 1'b1, 1'b0);
        press_dir(0, 1'b0, 1'b1);
        press_dir(0, 1'b1, 1'b1);
        step();

        // Default instance: first draw, then ignored inputs in GUESS.
        press_confirm(0);
        wait_draw(0, 1'b0);
        press_dir(0, 1'b1, 1'b1);
        press_confirm(0);

        // Long run of draws across several games.
        while (draws < 10000) begin
            logic h;
            h = 1'($urandom_range(0, 1));
            press_dir(0, h, ~h);
            wait_draw(0, 1'b0);
            press_confirm(0);
            if (e_st[0] == ST_GO) begin
                press_confirm(0);
                wait_draw(0, 1'b0);
            end
        end

        // Reset in the middle of a draw.
        press_dir(0, 1'b1, 1'b0);
        async_reset_check();

        // Small instance, game 1: one wrong guess ends it with high_score 0.
        press_confirm(1);
        wait_draw(1, 1'b0);
        guess(1, 1'b1 ^ 1'b1);
        wait_draw(1, 1'b0);
        press_dir(1, 1'b1, 1'b0);
        press_confirm(1);
        step();

        // Game 2: five correct guesses saturate the 2-bit score at 3.
        press_confirm(1);
        wait_draw(1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            guess(1, 1'b1);
            wait_draw(1, 1'b0);
            press_confirm(1);
        end
        guess(1, 1'b0);
        wait_draw(1, 1'b0);
        press_confirm(1);

        // Game 3: final score 1 must leave high_score at 3.
        press_confirm(1);
        wait_draw(1, 1'b0);
        guess(1, 1'b1);
        wait_draw(1, 1'b0);
        press_confirm(1);
        guess(1, 1'b0);
        wait_draw(1, 1'b0);
        press_confirm(1);
        step();

        // Game 4: reset while sitting in RESULT.
        press_confirm(1);
        wait_draw(1, 1'b0);
        guess(1, 1'b1);
        wait_draw(1, 1'b0);
        step();
        async_reset_check();

        repeat (3) step();
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
